// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator: FSM state encodings,
// the default datapath width and the default reset/trap vectors.
package pc_gen_pkg;

    localparam int CpuWidth = 32;

    localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VEC_DEF  = 32'h0000_0100;

    typedef enum logic [1:0] {
        PC_ST_BOOT = 2'd0,
        PC_ST_RUN  = 2'd1,
        PC_ST_HALT = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_boot_cnt.sv
// Loadable down-counter that holds the PC generator in BOOT after reset.
// done_o is high once the count has reached zero; the count then saturates.
module pc_boot_cnt #(
    parameter int BOOT_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic en_i,
    output logic done_o
);
    localparam int CntW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CntW-1:0] LoadVal = CntW'(BOOT_CYCLES - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= LoadVal;
        end else if (en_i && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign done_o = (r_cnt == '0);

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: boot delay, valid/ready handshake,
// halt/resume, trap-over-jump redirects and misaligned-target trapping.
// Build option: define PC_RVC_EN for 16-bit instruction steps and 2-byte alignment.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               XLEN        = CpuWidth,
    parameter logic [XLEN-1:0]  RESET_VEC   = XLEN'(PC_RESET_VEC_DEF),
    parameter logic [XLEN-1:0]  TRAP_VEC    = XLEN'(PC_TRAP_VEC_DEF),
    parameter int               BOOT_CYCLES = 4
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            if_ready_i,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            trap_en_i,
    input  logic [XLEN-1:0] trap_addr_i,
    input  logic            halt_i,
    input  logic            resume_i,
    input  logic            inc2_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o,
    output logic [1:0]      state_o
);
    pc_state_e       r_state, w_state_next;
    logic [XLEN-1:0] r_pc, w_pc_next;
    logic            r_pc_valid;
    logic            r_misalign, w_misalign_next;
    logic [XLEN-1:0] r_misalign_addr, w_misalign_addr_next;

    logic            w_boot_done;
    logic            w_redir;
    logic [XLEN-1:0] w_target;
    logic            w_target_mis;
    logic [XLEN-1:0] w_step;

    pc_boot_cnt #(
        .BOOT_CYCLES (BOOT_CYCLES)
    ) u_boot_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en_i   (r_state == PC_ST_BOOT),
        .done_o (w_boot_done)
    );

    // Trap outranks jump when both request a redirect in the same cycle.
    assign w_redir  = trap_en_i | jump_en_i;
    assign w_target = trap_en_i ? trap_addr_i : jump_addr_i;

`ifdef PC_RVC_EN
    assign w_step       = inc2_i ? XLEN'(2) : XLEN'(4);
    assign w_target_mis = w_target[0];
`else
    logic w_unused_inc2;
    assign w_unused_inc2 = inc2_i;
    assign w_step        = XLEN'(4);
    assign w_target_mis  = (w_target[1:0] != 2'b00);
`endif

    always_comb begin
        w_state_next         = r_state;
        w_pc_next            = r_pc;
        w_misalign_next      = 1'b0;
        w_misalign_addr_next = r_misalign_addr;
        case (r_state)
            PC_ST_BOOT: begin
                if (w_boot_done) w_state_next = PC_ST_RUN;
            end
            PC_ST_RUN: begin
                if (w_redir) begin
                    if (w_target_mis) begin
                        w_pc_next            = TRAP_VEC;
                        w_misalign_next      = 1'b1;
                        w_misalign_addr_next = w_target;
                    end else begin
                        w_pc_next = w_target;
                    end
                end else if (halt_i) begin
                    w_state_next = PC_ST_HALT;
                end else if (r_pc_valid && if_ready_i) begin
                    w_pc_next = r_pc + w_step;
                end
            end
            PC_ST_HALT: begin
                if (w_redir) begin
                    if (w_target_mis) begin
                        w_pc_next            = TRAP_VEC;
                        w_misalign_next      = 1'b1;
                        w_misalign_addr_next = w_target;
                        w_state_next         = PC_ST_RUN;
                    end else begin
                        w_pc_next = w_target;
                        if (trap_en_i) w_state_next = PC_ST_RUN;
                    end
                end else if (resume_i) begin
                    w_state_next = PC_ST_RUN;
                end
            end
            default: w_state_next = PC_ST_BOOT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state         <= PC_ST_BOOT;
            r_pc            <= RESET_VEC;
            r_pc_valid      <= 1'b0;
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_state         <= w_state_next;
            r_pc            <= w_pc_next;
            r_pc_valid      <= (w_state_next == PC_ST_RUN);
            r_misalign      <= w_misalign_next;
            r_misalign_addr <= w_misalign_addr_next;
        end
    end

    assign pc_o            = r_pc;
    assign pc_valid_o      = r_pc_valid;
    assign misalign_o      = r_misalign;
    assign misalign_addr_o = r_misalign_addr;
    assign state_o         = r_state;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (RESET_VEC=8000_0000, BOOT_CYCLES=4);
// expectations follow PC_RVC_EN when it is defined for the build.
module tb_pc_gen;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        if_ready_i;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        trap_en_i;
    logic [31:0] trap_addr_i;
    logic        halt_i;
    logic        resume_i;
    logic        inc2_i;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;
    logic [1:0]  state_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_pc;

    pc_gen #(
        .XLEN        (32),
        .RESET_VEC   (32'h8000_0000),
        .TRAP_VEC    (32'h0000_0100),
        .BOOT_CYCLES (4)
    ) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .if_ready_i      (if_ready_i),
        .jump_en_i       (jump_en_i),
        .jump_addr_i     (jump_addr_i),
        .trap_en_i       (trap_en_i),
        .trap_addr_i     (trap_addr_i),
        .halt_i          (halt_i),
        .resume_i        (resume_i),
        .inc2_i          (inc2_i),
        .pc_o            (pc_o),
        .pc_valid_o      (pc_valid_o),
        .misalign_o      (misalign_o),
        .misalign_addr_o (misalign_addr_o),
        .state_o         (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rstn_i = 1'b0; if_ready_i = 1'b0; jump_en_i = 1'b0; jump_addr_i = '0;
        trap_en_i = 1'b0; trap_addr_i = '0; halt_i = 1'b0; resume_i = 1'b0; inc2_i = 1'b0;
        #12;
        check("rst_pc",       pc_o, 32'h8000_0000);
        check("rst_valid",    {31'b0, pc_valid_o}, 32'd0);
        check("rst_misalign", {31'b0, misalign_o}, 32'd0);
        check("rst_mis_addr", misalign_addr_o, 32'd0);
        check("rst_state",    {30'b0, state_o}, 32'd0);

        // Release reset between edges; a jump during BOOT must be ignored.
        @(negedge clk_i);
        rstn_i = 1'b1;
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0300;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("boot_valid_%0d", i), {31'b0, pc_valid_o}, 32'd0);
        end
        tick();
        jump_en_i = 1'b0;
        check("boot_done_valid", {31'b0, pc_valid_o}, 32'd1);
        check("boot_done_pc",    pc_o, 32'h8000_0000);
        check("boot_done_state", {30'b0, state_o}, 32'd1);

        // Handshake: ready 1,0,1.
        if_ready_i = 1'b1; tick(); check("inc_1",  pc_o, 32'h8000_0004);
        if_ready_i = 1'b0; tick(); check("hold",   pc_o, 32'h8000_0004);
        if_ready_i = 1'b1; tick(); check("inc_2",  pc_o, 32'h8000_0008);

        // Trap beats jump, taken without ready.
        if_ready_i = 1'b0;
        trap_en_i = 1'b1; trap_addr_i = 32'h0000_0200;
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0300;
        tick();
        trap_en_i = 1'b0; jump_en_i = 1'b0;
        check("trap_prio", pc_o, 32'h0000_0200);

        // Jump target with bit 1 set.
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0102;
        tick();
        jump_en_i = 1'b0;
`ifdef PC_RVC_EN
        exp_pc = 32'h0000_0102;
        check("mis_pc",    pc_o, exp_pc);
        check("mis_pulse", {31'b0, misalign_o}, 32'd0);
`else
        exp_pc = 32'h0000_0100;
        check("mis_pc",    pc_o, exp_pc);
        check("mis_pulse", {31'b0, misalign_o}, 32'd1);
        check("mis_addr",  misalign_addr_o, 32'h0000_0102);
`endif
        tick();
        check("mis_pulse_end", {31'b0, misalign_o}, 32'd0);

        // Halt even with ready high: pc held, valid drops.
        if_ready_i = 1'b1; halt_i = 1'b1;
        tick();
        halt_i = 1'b0; if_ready_i = 1'b0;
        check("halt_valid", {31'b0, pc_valid_o}, 32'd0);
        check("halt_state", {30'b0, state_o}, 32'd2);
        check("halt_pc",    pc_o, exp_pc);
        if_ready_i = 1'b1; tick(); if_ready_i = 1'b0;
        check("halt_pc_no_inc", pc_o, exp_pc);

        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0400;
        tick();
        jump_en_i = 1'b0;
        check("halt_jump_pc",    pc_o, 32'h0000_0400);
        check("halt_jump_state", {30'b0, state_o}, 32'd2);

        resume_i = 1'b1; tick(); resume_i = 1'b0;
        check("resume_state", {30'b0, state_o}, 32'd1);
        check("resume_valid", {31'b0, pc_valid_o}, 32'd1);
        check("resume_pc",    pc_o, 32'h0000_0400);

        // Misaligned (odd) jump from HALT traps and returns to RUN.
        halt_i = 1'b1; tick(); halt_i = 1'b0;
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0401;
        tick();
        jump_en_i = 1'b0;
        check("halt_mis_pc",    pc_o, 32'h0000_0100);
        check("halt_mis_state", {30'b0, state_o}, 32'd1);
        check("halt_mis_pulse", {31'b0, misalign_o}, 32'd1);
        check("halt_mis_addr",  misalign_addr_o, 32'h0000_0401);

        // Wrap-around.
        jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC; tick(); jump_en_i = 1'b0;
        check("wrap_setup", pc_o, 32'hFFFF_FFFC);
        if_ready_i = 1'b1; tick(); if_ready_i = 1'b0;
        check("wrap", pc_o, 32'h0000_0000);

        // Compressed step.
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0010; tick(); jump_en_i = 1'b0;
        inc2_i = 1'b1; if_ready_i = 1'b1; tick(); inc2_i = 1'b0; if_ready_i = 1'b0;
`ifdef PC_RVC_EN
        check("inc2_step", pc_o, 32'h0000_0012);
`else
        check("inc2_step", pc_o, 32'h0000_0014);
`endif

        // Asynchronous reset mid-run.
        @(negedge clk_i);
        #2;
        rstn_i = 1'b0;
        #1;
        check("arst_pc",       pc_o, 32'h8000_0000);
        check("arst_valid",    {31'b0, pc_valid_o}, 32'd0);
        check("arst_state",    {30'b0, state_o}, 32'd0);
        check("arst_mis_addr", misalign_addr_o, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
